// File: rtl/uart_tx_sched.sv
// uart_tx_sched: one UART transmit serializer shared by NUM_REQ requesters.
// A round-robin arbiter picks a requester in IDLE. The frame is start,
// DATA_W data bits sent LSB first, an optional even-parity bit, then stop.
// Each bit lasts SMP_RATE baud_tick pulses. All outputs are registered.
module uart_tx_sched #(
    parameter int NUM_REQ   = 2,
    parameter int DATA_W    = 8,
    parameter int SMP_RATE  = 16,
    parameter int PARITY_EN = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       baud_tick,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  data_in,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       tx,
    output logic                       busy,
    output logic                       done
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(SMP_RATE);
    localparam int BW = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t              state;
    logic [PW-1:0]       ptr;
    logic [TW-1:0]       tick_cnt;
    logic [BW-1:0]       bit_cnt;
    logic [DATA_W-1:0]   shreg;
    logic                par_bit;

    logic                hit;
    logic [PW-1:0]       sel;
    logic [PW-1:0]       idx;
    logic [PW-1:0]       ptr_nxt;
    logic [NUM_REQ-1:0]  gnt_nxt;
    logic [DATA_W-1:0]   byte_sel;
    logic                bnd;
    int                  j;

    // Round-robin search: first set req bit at or above ptr, wrapping around.
    always_comb begin
        hit      = 1'b0;
        sel      = '0;
        idx      = '0;
        j        = 0;
        gnt_nxt  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            idx = PW'(j);
            if (!hit && req[idx]) begin
                hit = 1'b1;
                sel = idx;
            end
        end
        gnt_nxt[sel] = hit;
        ptr_nxt      = (sel == PW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
        byte_sel     = data_in[int'(sel)*DATA_W +: DATA_W];
    end

    // A bit period ends on the SMP_RATE-th baud_tick counted in that bit.
    assign bnd = baud_tick && (tick_cnt == TW'(SMP_RATE - 1));

    // Frame sequencer; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            ptr      <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            gnt      <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            gnt  <= '0;
            done <= 1'b0;
            if (state == S_IDLE) begin
                // ticks seen while idle do not count toward the start bit
                tick_cnt <= '0;
                if (hit) begin
                    gnt     <= gnt_nxt;
                    shreg   <= byte_sel;
                    par_bit <= ^byte_sel;
                    ptr     <= ptr_nxt;
                    state   <= S_START;
                    tx      <= 1'b0;
                    busy    <= 1'b1;
                end
            end else if (baud_tick) begin
                tick_cnt <= bnd ? '0 : tick_cnt + 1'b1;
                if (bnd) begin
                    case (state)
                        S_START: begin
                            tx      <= shreg[0];
                            bit_cnt <= '0;
                            state   <= S_DATA;
                        end
                        S_DATA: begin
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == BW'(DATA_W - 1)) begin
                                if (PARITY_EN != 0) begin
                                    tx    <= par_bit;
                                    state <= S_PARITY;
                                end else begin
                                    tx    <= 1'b1;
                                    state <= S_STOP;
                                end
                            end else begin
                                tx <= shreg[1];
                            end
                        end
                        S_PARITY: begin
                            tx    <= 1'b1;
                            state <= S_STOP;
                        end
                        S_STOP: begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: SMP_RATE=4 with a baud_tick every 3rd clk.
// One instance runs without parity and a second runs with parity enabled.
module tb_uart_tx_sched;
    localparam int SR = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        baud_tick = 1'b0;
    logic [1:0]  req = '0;
    logic [1:0]  req_p = '0;
    logic [15:0] data_in = '0;
    logic [15:0] data_p = '0;
    logic [1:0]  gnt, gnt_p;
    logic        tx, busy, done, tx_p, busy_p, done_p;

    int nvec = 0;
    int nerr = 0;
    int bph = 0;

    uart_tx_sched #(.NUM_REQ(2), .DATA_W(8), .SMP_RATE(SR), .PARITY_EN(0)) dut (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .req(req), .data_in(data_in),
        .gnt(gnt), .tx(tx), .busy(busy), .done(done));

    uart_tx_sched #(.NUM_REQ(2), .DATA_W(8), .SMP_RATE(SR), .PARITY_EN(1)) dutp (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .req(req_p), .data_in(data_p),
        .gnt(gnt_p), .tx(tx_p), .busy(busy_p), .done(done_p));

    always #5 clk = ~clk;

    // baud_tick is high for one clk out of every three
    always @(negedge clk) begin
        bph = (bph == 2) ? 0 : bph + 1;
        baud_tick = (bph == 0);
    end

    task automatic wait_gnt(input bit par, input logic [1:0] exp, input string nm, output int cyc);
        logic [1:0] g;
        g = '0;
        cyc = 0;
        while (g == 2'b00 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            g = par ? gnt_p : gnt;
        end
        nvec++;
        if (g !== exp) begin
            nerr++;
            $display("FAIL %s: gnt got %b want %b after %0d clks", nm, g, exp, cyc);
        end
    endtask

    // Called right after the grant sample; follows the frame to its done pulse.
    task automatic check_frame(input bit par, input logic [7:0] d, input bit pbit, input string nm);
        bit   bits[11];
        int   nb, tc, cyc, bi;
        bit   bad;
        logic t, o_tx, o_busy, o_done;
        logic [1:0] o_g;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        if (par) begin
            bits[9] = pbit; bits[10] = 1'b1; nb = 11;
        end else begin
            bits[9] = 1'b1; bits[10] = 1'b1; nb = 10;
        end
        tc = 0; cyc = 0; bad = 1'b0;
        o_tx = par ? tx_p : tx;   o_busy = par ? busy_p : busy;
        o_done = par ? done_p : done; o_g = par ? gnt_p : gnt;
        while (tc < nb*SR && cyc < 1000) begin
            bi = tc / SR;
            if (!bad && (o_tx !== bits[bi] || o_busy !== 1'b1 || o_done !== 1'b0 ||
                         (cyc != 0 && o_g !== 2'b00))) begin
                bad = 1'b1;
                $display("FAIL %s: bit %0d tick %0d got tx=%b busy=%b done=%b gnt=%b want tx=%b busy=1 done=0",
                         nm, bi, tc, o_tx, o_busy, o_done, o_g, bits[bi]);
            end
            @(posedge clk); t = baud_tick; #1;
            cyc++;
            if (t) tc++;
            o_tx = par ? tx_p : tx;   o_busy = par ? busy_p : busy;
            o_done = par ? done_p : done; o_g = par ? gnt_p : gnt;
        end
        nvec++;
        if (bad) nerr++;
        nvec++;
        if (tc != nb*SR || o_done !== 1'b1 || o_busy !== 1'b0 || o_tx !== 1'b1) begin
            nerr++;
            $display("FAIL %s end: ticks=%0d done=%b busy=%b tx=%b want ticks=%0d done=1 busy=0 tx=1",
                     nm, tc, o_done, o_busy, o_tx, nb*SR);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req = '0; req_p = '0;
        for (int c = 0; c < 10; c++) begin
            if (c == 5) rst = 1'b1;
            @(posedge clk); #1;
            nvec++;
            if ({tx, busy, gnt, done, tx_p, busy_p, gnt_p, done_p} !== 12'b1_0_00_0_1_0_00_0) begin
                nerr++;
                $display("FAIL reset clk %0d: got tx=%b busy=%b gnt=%b done=%b / tx=%b busy=%b gnt=%b done=%b want 1 0 00 0",
                         c, tx, busy, gnt, done, tx_p, busy_p, gnt_p, done_p);
            end
        end
    endtask

    task automatic test_single();
        data_in[7:0] = 8'hA5;
        req = 2'b01;
        @(posedge clk); #1;
        nvec++;
        if (gnt !== 2'b01) begin
            nerr++;
            $display("FAIL single latency: gnt got %b want 01 one clk after req", gnt);
        end
        req = '0;
        check_frame(1'b0, 8'hA5, 1'b0, "single A5");
        repeat (3) @(posedge clk);
        #1;
    endtask

    // req[1] rises mid-frame; data_in[7:0] is also disturbed after the grant
    task automatic test_mid_request();
        int cyc;
        data_in[7:0] = 8'h33;
        req = 2'b01;
        wait_gnt(1'b0, 2'b01, "mid first gnt", cyc);
        req = '0;
        fork
            check_frame(1'b0, 8'h33, 1'b0, "mid frame 33");
            begin
                repeat (20) @(posedge clk);
                #1;
                data_in[7:0]  = 8'hFF;
                data_in[15:8] = 8'h44;
                req[1] = 1'b1;
            end
        join
        wait_gnt(1'b0, 2'b10, "mid second gnt", cyc);
        nvec++;
        if (cyc != 1) begin
            nerr++;
            $display("FAIL mid idle gap: gnt after %0d clks want 1", cyc);
        end
        req = '0;
        check_frame(1'b0, 8'h44, 1'b0, "mid frame 44");
    endtask

    task automatic test_round_robin();
        int cyc;
        data_in = 16'h2211;
        req = 2'b11;
        for (int f = 0; f < 4; f++) begin
            if (f % 2 == 0) begin
                wait_gnt(1'b0, 2'b01, "rr gnt", cyc);
                if (f == 3) req = '0;
                check_frame(1'b0, 8'h11, 1'b0, "rr frame 11");
            end else begin
                wait_gnt(1'b0, 2'b10, "rr gnt", cyc);
                if (f == 3) req = '0;
                check_frame(1'b0, 8'h22, 1'b0, "rr frame 22");
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_parity();
        int cyc;
        data_p[7:0] = 8'h07;
        req_p = 2'b01;
        wait_gnt(1'b1, 2'b01, "par gnt 07", cyc);
        req_p = '0;
        check_frame(1'b1, 8'h07, 1'b1, "parity 07");
        data_p[7:0] = 8'h03;
        req_p = 2'b01;
        wait_gnt(1'b1, 2'b01, "par gnt 03", cyc);
        req_p = '0;
        check_frame(1'b1, 8'h03, 1'b0, "parity 03");
    endtask

    task automatic test_reset_mid();
        int cyc, tc;
        logic t;
        data_in[7:0] = 8'h5A;
        req = 2'b01;
        wait_gnt(1'b0, 2'b01, "rst-mid first gnt", cyc);
        req = '0;
        tc = 0; cyc = 0;
        while (tc < 17 && cyc < 200) begin
            @(posedge clk); t = baud_tick; #1;
            cyc++;
            if (t) tc++;
        end
        nvec++;
        if (busy !== 1'b1 || tx !== 1'b1) begin
            nerr++;
            $display("FAIL rst-mid data bit 3: busy=%b tx=%b want busy=1 tx=1", busy, tx);
        end
        rst = 1'b0;
        req = 2'b11;
        @(posedge clk); #1;
        nvec++;
        if (tx !== 1'b1 || busy !== 1'b0 || gnt !== 2'b00 || done !== 1'b0) begin
            nerr++;
            $display("FAIL rst-mid edge: tx=%b busy=%b gnt=%b done=%b want 1 0 00 0", tx, busy, gnt, done);
        end
        rst = 1'b1;
        wait_gnt(1'b0, 2'b01, "rst-mid pointer", cyc);
        req = '0;
        check_frame(1'b0, 8'h5A, 1'b0, "rst-mid frame 5A");
    endtask

    initial begin
        test_reset();
        test_single();
        test_mid_request();
        test_round_robin();
        test_parity();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Single UART transmit serializer shared by NUM_REQ requesters through a round-robin arbiter.
- Consumes the oversampled baud_tick from the baud rate generator; each serial bit lasts SMP_RATE ticks.
- Sequences start, data (LSB first), optional even-parity and stop bits on tx.
- Sits between the host-side message sources and the UART pad.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_W, 8, data bits per frame (5..9).
- SMP_RATE, 16, baud_tick pulses per serial bit (>=2); must match the generator's smp_rate.
- PARITY_EN, 0, 1 = insert even-parity bit between data and stop.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-low (0 = reset), sampled on posedge clk.
- baud_tick  input  1  one-clk pulse from the baud rate generator, SMP_RATE per bit.
- req  input  NUM_REQ  per-requester transmit request, level; held until granted.
- data_in  input  NUM_REQ*DATA_W  requester i's byte at bits [i*DATA_W +: DATA_W]; stable while req[i]=1.
- gnt  output  NUM_REQ  one-hot, one-clk pulse: requester's data was latched.
- tx  output  1  serial line, idle high.
- busy  output  1  high from the grant cycle until the stop bit completes.
- done  output  1  one-clk pulse at end of stop bit.

Behaviour:
- Reset (rst=0 at posedge):
  - Outputs: tx=1, busy=0, gnt=0, done=0.
  - State=IDLE, rr pointer=0, tick_cnt=0, bit_cnt=0.
  - Applies mid-frame: the frame is abandoned and tx returns high on that edge.
- States: IDLE -> START -> DATA -> [PARITY if PARITY_EN] -> STOP -> IDLE.
- IDLE arbitration:
  - If any req bit is set, grant the first set bit searching upward from pointer, wrapping modulo NUM_REQ.
  - Registered outputs on the next edge: gnt[k]=1 for one clk, shift register <= data_in slice k, pointer <= (k+1) mod NUM_REQ, state=START, tx=0, busy=1, tick_cnt=0.
- Bit timing:
  - tick_cnt increments on each baud_tick.
  - When baud_tick=1 and tick_cnt==SMP_RATE-1: tick_cnt <= 0 and the bit boundary is reached.
  - tick_cnt width is $clog2(SMP_RATE).
  - The start bit is SMP_RATE ticks, measured from the first baud_tick after grant.
- START -> DATA at boundary:
  - tx = shreg[0], bit_cnt=0.
- DATA, each boundary:
  - Shift right; bit_cnt++; tx = next LSB.
  - After the DATA_W-th bit: go to PARITY (tx = XOR of the latched byte) or STOP (tx=1).
  - bit_cnt width is $clog2(DATA_W+1).
- PARITY -> STOP at boundary: tx=1.
- STOP -> IDLE at boundary:
  - done=1 for one clk, busy=0, tx stays 1.
  - Arbitration resumes the following cycle, so there is at least one idle clk between frames.
- req changes:
  - req asserted during a frame waits; no gnt is issued while busy.
  - req deasserted before grant withdraws the request with no side effects.
- baud_tick arriving in IDLE is ignored; tick_cnt stays 0.
- Data integrity: data_in changes after gnt do not affect the frame in flight.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0.
- tx, gnt, busy and done are all registered outputs; there are no combinational paths from inputs.

Test Plan:
- Reset/idle: hold rst=0 for 5 clks, then release with req=0 -> tx=1, busy=0, gnt=0, done=0 throughout.
- Single frame: SMP_RATE=4, baud_tick every 3rd clk, req[0]=1, data=8'hA5.
  - gnt[0] pulses 1 clk after req.
  - tx = 0, then 1,0,1,0,0,1,0,1, then 1, each bit held exactly 4 ticks (12 clks).
  - done pulses once; busy falls with done.
- Round robin: req=2'b11 held, data0=8'h11, data1=8'h22 -> frames go out in order 11,22,11,22; gnt alternates 01,10,01,10.
- Parity: PARITY_EN=1, data=8'h07 -> parity bit=1 inserted before stop; data=8'h03 -> parity bit=0.
- Reset mid-frame: assert rst=0 during data bit 3 -> tx=1 and busy=0 on that edge; pointer back to 0; the next grant goes to requester 0 even if 1 was due.
- Mid-frame request: req[1] rises during a frame from requester 0 -> gnt[1] appears only after done, with at least 1 idle clk at tx=1 between the two stop/start bits.
